sobel_edge_detect: RTL

Streaming 3×3 Sobel edge detector on 8-bit grayscale camera-timing video. It sits directly downstream of the median filter and takes its `pos_frame_vsync` / `pos_frame_href` / `pos_img_y` outputs unchanged. It emits a binarised edge map (0x00 / 0xFF) with the same sync timing, delayed by a fixed latency, so the frame-dump bench stores it exactly like median output.

---
 rtl/sobel_edge_detect.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sobel_edge_detect.sv
// sobel_edge_detect: streaming 3x3 Sobel edge detector on 8-bit grayscale
// camera-timing video. Emits a binarised edge map (8'hFF / 8'h00) with the
// input vsync/href delayed by exactly 4 clk.
//
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   per_frame_vsync   input frame sync (rising edge = frame start)
//   per_frame_href    input line valid, one pixel per clk while high
//   per_img_y         input gray pixel
//   edge_threshold    magnitude threshold (changes only while vsync=1)
//   pos_frame_vsync   vsync delayed 4 clk
//   pos_frame_href    href delayed 4 clk
//   pos_img_y         8'hFF where |Gx|+|Gy| > threshold, else 8'h00
module sobel_edge_detect #(
  parameter int IMG_WIDTH = 640
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic [7:0]  per_img_y,
  input  logic [10:0] edge_threshold,
  output logic        pos_frame_vsync,
  output logic        pos_frame_href,
  output logic [7:0]  pos_img_y
);
  localparam int STAGES = 4;
  localparam int CW     = $clog2(IMG_WIDTH + 1);
  localparam int AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  logic [CW-1:0] col;
  logic [10:0]   row, row_cur;
  logic          vs_d, hs_d, vs_rise, accept, border_ok;
  logic [AW-1:0] addr;
  logic [7:0]    tap0, tap1;

  logic [7:0] lb0 [IMG_WIDTH];
  logic [7:0] lb1 [IMG_WIDTH];

  // win[r][c]: r=0 oldest line .. r=2 current line; c=0 oldest .. c=2 newest
  logic [2:0][2:0][7:0] win;
  logic [9:0]  sum_l, sum_r, sum_t, sum_b;
  logic [9:0]  gx_abs, gy_abs;
  logic [10:0] mag;
  logic        b1, b2, b3;
  logic [STAGES:1] vs_pipe, hs_pipe;

  assign vs_rise = per_frame_vsync & ~vs_d;
  assign accept  = per_frame_href && (col < CW'(IMG_WIDTH));
  assign addr    = col[AW-1:0];
  assign tap0    = lb0[addr];
  assign tap1    = lb1[addr];
  // A vsync edge coinciding with the first pixel must already see row 0.
  assign row_cur   = vs_rise ? 11'd0 : row;
  assign border_ok = accept && (col >= CW'(2)) && (row_cur >= 11'd2);

  // Line/column counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      vs_d <= 1'b0;
      hs_d <= 1'b0;
    end else begin
      vs_d <= per_frame_vsync;
      hs_d <= per_frame_href;
      if (!per_frame_href)             col <= '0;
      else if (col != CW'(IMG_WIDTH))  col <= col + CW'(1);
      if (vs_rise)                                         row <= '0;
      else if (hs_d && !per_frame_href && row != 11'h7FF)  row <= row + 11'd1;
    end
  end

  // Line buffers: no reset, border mask hides unwritten contents
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[addr] <= tap0;
      lb0[addr] <= per_img_y;
    end
  end

  // Stage 1: window shift + border flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
      b1  <= 1'b0;
    end else begin
      b1 <= border_ok;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= tap1;
        win[1][2] <= tap0;
        win[2][2] <= per_img_y;
      end
    end
  end

  // Stage 2: weighted edge sums; stage 3: magnitude; stage 4: threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_l     <= '0;
      sum_r     <= '0;
      sum_t     <= '0;
      sum_b     <= '0;
      b2        <= 1'b0;
      mag       <= '0;
      b3        <= 1'b0;
      pos_img_y <= 8'h00;
      vs_pipe   <= '0;
      hs_pipe   <= '0;
    end else begin
      sum_l <= 10'(win[0][0]) + (10'(win[1][0]) << 1) + 10'(win[2][0]);
      sum_r <= 10'(win[0][2]) + (10'(win[1][2]) << 1) + 10'(win[2][2]);
      sum_t <= 10'(win[0][0]) + (10'(win[0][1]) << 1) + 10'(win[0][2]);
      sum_b <= 10'(win[2][0]) + (10'(win[2][1]) << 1) + 10'(win[2][2]);
      b2    <= b1;
      mag   <= 11'(gx_abs) + 11'(gy_abs);
      b3    <= b2;
      pos_img_y <= (b3 && (mag > edge_threshold)) ? 8'hFF : 8'h00;
      vs_pipe <= {vs_pipe[STAGES-1:1], per_frame_vsync};
      hs_pipe <= {hs_pipe[STAGES-1:1], per_frame_href};
    end
  end

  assign gx_abs = (sum_r >= sum_l) ? (sum_r - sum_l) : (sum_l - sum_r);
  assign gy_abs = (sum_t >= sum_b) ? (sum_t - sum_b) : (sum_b - sum_t);

  assign pos_frame_vsync = vs_pipe[STAGES];
  assign pos_frame_href  = hs_pipe[STAGES];

endmodule
